// File: rtl/gesture_sequencer_if.sv
// Program-write, play-control and gesture-output bundle of the gesture sequencer.
// The master side drives programming and control; the slave side is the sequencer.
interface gesture_sequencer_if #(
  parameter int DEPTH = 8
) ();
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_gesture;
  logic [7:0]    wr_dwell;
  logic [AW:0]   play_len;
  logic          loop_en;
  logic          start;
  logic          abort;
  logic [7:0]    gesture;
  logic          busy;
  logic [AW-1:0] step;
  logic          done;

  modport master (
    output wr_en, wr_addr, wr_gesture, wr_dwell, play_len, loop_en, start, abort,
    input  gesture, busy, step, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_gesture, wr_dwell, play_len, loop_en, start, abort,
    output gesture, busy, step, done
  );
endinterface

// File: rtl/gesture_sequencer.sv
// Plays a programmed list of {gesture, dwell} steps to the gesture decoder,
// holding each gesture for max(dwell,1) dwell units, optionally looping.
module gesture_sequencer #(
  parameter int DEPTH          = 8,
  parameter int DWELL_UNIT_CYC = 5_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  gesture_sequencer_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int UCW = (DWELL_UNIT_CYC > 1) ? $clog2(DWELL_UNIT_CYC) : 1;
  localparam logic [UCW-1:0] UNIT_LAST  = UCW'(DWELL_UNIT_CYC - 1);
  localparam logic [UCW-1:0] UNIT_ONE   = UCW'(1);
  localparam logic [AW:0]    DEPTH_LEN  = (AW+1)'(DEPTH);
  localparam logic [AW:0]    LEN_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0]  FIRST_STEP = AW'(0);
  localparam logic [AW-1:0]  STEP_ONE   = AW'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // A zero dwell still plays for one unit, so the down-counter preload is max(d,1)-1.
  function automatic logic [7:0] units_preload(input logic [7:0] dwell);
    units_preload = (dwell == 8'd0) ? 8'd0 : (dwell - 8'd1);
  endfunction

  logic [15:0]    prog_r [DEPTH];
  state_e         state_r,      state_nxt_s;
  logic [7:0]     gesture_r,    gesture_nxt_s;
  logic [AW-1:0]  step_r,       step_nxt_s;
  logic           done_r,       done_nxt_s;
  logic [UCW-1:0] unit_cnt_r,   unit_cnt_nxt_s;
  logic [7:0]     units_left_r, units_left_nxt_s;
  logic [AW:0]    len_r,        len_nxt_s;
  logic           loop_r,       loop_nxt_s;

  logic           start_ok_s;
  logic           unit_end_s;
  logic           last_step_s;
  logic [AW-1:0]  step_inc_s;

  assign start_ok_s  = (bus.play_len != {(AW+1){1'b0}}) && (bus.play_len <= DEPTH_LEN);
  assign unit_end_s  = (unit_cnt_r == UNIT_LAST);
  assign last_step_s = ({1'b0, step_r} == (len_r - LEN_ONE));
  assign step_inc_s  = step_r + STEP_ONE;

  // Program register file: writable only while idle so a running sequence is never disturbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog_r[i] <= 16'h0000;
      end
    end else if (bus.wr_en && (state_r == ST_IDLE)) begin
      prog_r[bus.wr_addr] <= {bus.wr_gesture, bus.wr_dwell};
    end
  end

  // Next-state and next-output decode; abort always takes priority over start and step advance.
  always_comb begin
    state_nxt_s      = state_r;
    gesture_nxt_s    = gesture_r;
    step_nxt_s       = step_r;
    done_nxt_s       = 1'b0;
    unit_cnt_nxt_s   = unit_cnt_r;
    units_left_nxt_s = units_left_r;
    len_nxt_s        = len_r;
    loop_nxt_s       = loop_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.abort) begin
          gesture_nxt_s = 8'h00;
        end else if (bus.start && start_ok_s) begin
          state_nxt_s      = ST_PLAY;
          len_nxt_s        = bus.play_len;
          loop_nxt_s       = bus.loop_en;
          step_nxt_s       = FIRST_STEP;
          gesture_nxt_s    = prog_r[FIRST_STEP][15:8];
          unit_cnt_nxt_s   = {UCW{1'b0}};
          units_left_nxt_s = units_preload(prog_r[FIRST_STEP][7:0]);
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (bus.abort) begin
          state_nxt_s      = ST_IDLE;
          gesture_nxt_s    = 8'h00;
          step_nxt_s       = FIRST_STEP;
          unit_cnt_nxt_s   = {UCW{1'b0}};
          units_left_nxt_s = 8'd0;
        end else if (!unit_end_s) begin
          unit_cnt_nxt_s = unit_cnt_r + UNIT_ONE;
        end else if (units_left_r != 8'd0) begin
          unit_cnt_nxt_s   = {UCW{1'b0}};
          units_left_nxt_s = units_left_r - 8'd1;
        end else if (!last_step_s) begin
          step_nxt_s       = step_inc_s;
          gesture_nxt_s    = prog_r[step_inc_s][15:8];
          unit_cnt_nxt_s   = {UCW{1'b0}};
          units_left_nxt_s = units_preload(prog_r[step_inc_s][7:0]);
        end else if (loop_r) begin
          step_nxt_s       = FIRST_STEP;
          gesture_nxt_s    = prog_r[FIRST_STEP][15:8];
          unit_cnt_nxt_s   = {UCW{1'b0}};
          units_left_nxt_s = units_preload(prog_r[FIRST_STEP][7:0]);
        end else begin
          state_nxt_s    = ST_IDLE;
          done_nxt_s     = 1'b1;
          unit_cnt_nxt_s = {UCW{1'b0}};
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        gesture_nxt_s = 8'h00;
        step_nxt_s    = FIRST_STEP;
      end
    endcase
  end

  // State, output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      gesture_r    <= 8'h00;
      step_r       <= FIRST_STEP;
      done_r       <= 1'b0;
      unit_cnt_r   <= {UCW{1'b0}};
      units_left_r <= 8'd0;
      len_r        <= {(AW+1){1'b0}};
      loop_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      gesture_r    <= gesture_nxt_s;
      step_r       <= step_nxt_s;
      done_r       <= done_nxt_s;
      unit_cnt_r   <= unit_cnt_nxt_s;
      units_left_r <= units_left_nxt_s;
      len_r        <= len_nxt_s;
      loop_r       <= loop_nxt_s;
    end
  end

  assign bus.gesture = gesture_r;
  assign bus.step    = step_r;
  assign bus.busy    = (state_r == ST_PLAY);
  assign bus.done    = done_r;
endmodule

// File: tb/tb_gesture_sequencer.sv
// Scoreboard bench for gesture_sequencer: stimulus queues expected output events,
// a negedge monitor pops them whenever gesture/step/busy change or done pulses.
module tb_gesture_sequencer;
  localparam int DEPTH = 8;
  localparam int UNIT  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gesture_sequencer_if #(.DEPTH(DEPTH)) bus ();

  gesture_sequencer #(
    .DEPTH          (DEPTH),
    .DWELL_UNIT_CYC (UNIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]  gesture;
    logic [2:0]  step;
    logic        busy;
    logic        done;
    logic [15:0] gap;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // gap = negedges since the previous output event; 0 means do not check timing
  task automatic expect_ev(input logic [7:0] g, input logic [2:0] s, input logic b,
                           input logic d, input int gap);
    ev_t e;
    e.gesture = g;
    e.step    = s;
    e.busy    = b;
    e.done    = d;
    e.gap     = 16'(gap);
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    logic [11:0] prev;
    logic [11:0] cur;
    ev_t         e;
    int          cyc;
    int          last_ev;
    prev    = 12'h000;
    cyc     = 0;
    last_ev = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {bus.gesture, bus.step, bus.busy};
      if ((cur != prev) || bus.done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got g=%02h s=%0d busy=%b done=%b, required no event",
                   bus.gesture, bus.step, bus.busy, bus.done);
        end else begin
          e = exp_q.pop_front();
          if (({bus.gesture, bus.step, bus.busy, bus.done} != {e.gesture, e.step, e.busy, e.done}) ||
              ((e.gap != 16'd0) && ((cyc - last_ev) != int'(e.gap)))) begin
            errors++;
            $display("FAIL event: got g=%02h s=%0d busy=%b done=%b gap=%0d, required g=%02h s=%0d busy=%b done=%b gap=%0d",
                     bus.gesture, bus.step, bus.busy, bus.done, cyc - last_ev,
                     e.gesture, e.step, e.busy, e.done, e.gap);
          end
        end
        last_ev = cyc;
      end
      prev = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < max_cyc)) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d pending events, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic write_step(input logic [2:0] a, input logic [7:0] g, input logic [7:0] d);
    bus.wr_en      = 1'b1;
    bus.wr_addr    = a;
    bus.wr_gesture = g;
    bus.wr_dwell   = d;
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [3:0] len, input logic loop);
    bus.play_len = len;
    bus.loop_en  = loop;
    bus.start    = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
  endtask

  task automatic expect_once();
    expect_ev(8'h11, 3'd0, 1'b1, 1'b0, 0);
    expect_ev(8'h22, 3'd1, 1'b1, 1'b0, 4);
    expect_ev(8'h33, 3'd2, 1'b1, 1'b0, 8);
    expect_ev(8'h33, 3'd2, 1'b0, 1'b1, 4);
  endtask

  initial begin : stimulus
    bus.wr_en      = 1'b0;
    bus.wr_addr    = 3'd0;
    bus.wr_gesture = 8'h00;
    bus.wr_dwell   = 8'h00;
    bus.play_len   = 4'd0;
    bus.loop_en    = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    tick(2);
    check("reset_gesture", 32'(bus.gesture), 32'h00);
    check("reset_busy",    32'(bus.busy),    32'h0);
    check("reset_step",    32'(bus.step),    32'h0);
    check("reset_done",    32'(bus.done),    32'h0);
    rst_n = 1'b1;
    tick(1);

    write_step(3'd0, 8'h11, 8'd1);
    write_step(3'd1, 8'h22, 8'd2);
    write_step(3'd2, 8'h33, 8'd0);

    // single pass: 4 / 8 / 4 cycles then one done pulse
    expect_once();
    pulse_start(4'd3, 1'b0);
    drain(100, "once");
    tick(3);
    check("once_hold_gesture", 32'(bus.gesture), 32'h33);
    check("once_hold_step",    32'(bus.step),    32'h2);

    // looping pass wraps to step 0 with no done, then abort
    expect_ev(8'h11, 3'd0, 1'b1, 1'b0, 0);
    expect_ev(8'h22, 3'd1, 1'b1, 1'b0, 4);
    expect_ev(8'h33, 3'd2, 1'b1, 1'b0, 8);
    expect_ev(8'h11, 3'd0, 1'b1, 1'b0, 4);
    expect_ev(8'h22, 3'd1, 1'b1, 1'b0, 4);
    pulse_start(4'd3, 1'b1);
    drain(100, "loop");
    expect_ev(8'h00, 3'd0, 1'b0, 1'b0, 0);
    pulse_abort();
    drain(10, "abort_play");
    tick(3);
    check("abort_busy", 32'(bus.busy), 32'h0);

    // out-of-range lengths are ignored
    pulse_start(4'd0, 1'b0);
    tick(4);
    pulse_start(4'd9, 1'b0);
    tick(4);
    check("badlen_busy",    32'(bus.busy),    32'h0);
    check("badlen_gesture", 32'(bus.gesture), 32'h00);

    // writes and restarts during PLAY are dropped
    expect_once();
    pulse_start(4'd3, 1'b0);
    write_step(3'd1, 8'h55, 8'd7);
    pulse_start(4'd1, 1'b1);
    drain(100, "busy_write");
    expect_once();
    pulse_start(4'd3, 1'b0);
    drain(100, "replay");

    // start and abort together in IDLE: abort wins, only gesture is cleared
    expect_ev(8'h00, 3'd2, 1'b0, 1'b0, 0);
    bus.play_len = 4'd3;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    tick(1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drain(10, "start_abort");
    tick(3);
    check("start_abort_busy", 32'(bus.busy), 32'h0);

    // asynchronous reset mid step 1 clears outputs and program
    expect_ev(8'h11, 3'd0, 1'b1, 1'b0, 0);
    expect_ev(8'h22, 3'd1, 1'b1, 1'b0, 4);
    pulse_start(4'd3, 1'b0);
    drain(50, "pre_reset");
    tick(2);
    expect_ev(8'h00, 3'd0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    #1;
    check("async_rst_gesture", 32'(bus.gesture), 32'h00);
    check("async_rst_busy",    32'(bus.busy),    32'h0);
    tick(2);
    drain(10, "reset_event");
    rst_n = 1'b1;
    tick(1);
    expect_ev(8'h00, 3'd0, 1'b1, 1'b0, 0);
    expect_ev(8'h00, 3'd0, 1'b0, 1'b1, 4);
    pulse_start(4'd1, 1'b0);
    drain(50, "post_reset");
    tick(5);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gesture_sequencer.md
GESTURE_SEQUENCER -- requirements
Module: gesture_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of program steps (power of 2, address width AW = log2(DEPTH)).
REQ-002 SHALL have parameter DWELL_UNIT_CYC, default 5_000_000, clk cycles per dwell unit (100 ms at 50 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  program-write strobe.
REQ-006 SHALL have port wr_addr  input  AW  step index to write.
REQ-007 SHALL have port wr_gesture  input  8  gesture code for that step.
REQ-008 SHALL have port wr_dwell  input  8  step dwell in units.
REQ-009 SHALL have port play_len  input  AW+1  number of steps to play, valid 1..DEPTH.
REQ-010 SHALL have port loop_en  input  1  repeat sequence when set.
REQ-011 SHALL have port start  input  1  single-cycle start request.
REQ-012 SHALL have port abort  input  1  single-cycle stop request.
REQ-013 SHALL have port gesture  output  8  gesture code to the gesture decoder, registered.
REQ-014 SHALL have port busy  output  1  high while a sequence plays.
REQ-015 SHALL have port step  output  AW  index of current step.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-017 SHALL hold a DEPTH x 16-bit program register file {gesture, dwell}, written on wr_en in the cycle it is asserted, only when state = IDLE; writes while busy are dropped.
REQ-018 SHALL implement states IDLE and PLAY; busy = (state == PLAY).
REQ-019 In IDLE, start with 1 <= play_len <= DEPTH SHALL latch play_len and loop_en, set step = 0, load gesture = prog[0].gesture next cycle, enter PLAY.
REQ-020 start with play_len = 0 or > DEPTH SHALL be ignored (stay IDLE, no done).
REQ-021 start while in PLAY SHALL be ignored; play_len/loop_en changes during PLAY SHALL have no effect.
REQ-022 In PLAY each step SHALL last exactly max(dwell,1) * DWELL_UNIT_CYC cycles, counted by a unit-cycle counter and a unit-down-counter, both reloaded at every step entry.
REQ-023 At step end with step < len-1: step increments, gesture = prog[step+1].gesture on the next cycle, no gap cycle.
REQ-024 At last-step end with loop_en latched = 1: step wraps to 0, gesture = prog[0].gesture, remain in PLAY.
REQ-025 At last-step end with loop_en latched = 0: done = 1 for one cycle, enter IDLE, gesture holds last step's code, step holds len-1.
REQ-026 abort in PLAY SHALL enter IDLE next cycle, set gesture = 8'h00 (neutral), step = 0, no done pulse; abort in IDLE SHALL only force gesture = 8'h00.
REQ-027 abort and start in same cycle: abort wins, start ignored.
REQ-028 Program entries read at step entry SHALL reflect the last write completed before start.
REQ-029 Counters SHALL be wide enough for DWELL_UNIT_CYC-1 and 255 without overflow; no wrap.

Reset
REQ-030 rst_n low SHALL immediately force state = IDLE, gesture = 8'h00, step = 0, busy = 0, done = 0, counters = 0, all program entries = 16'h0000, independent of clk.
REQ-031 rst_n deasserted mid-sequence SHALL leave block in IDLE; no resumption.

Verification (DWELL_UNIT_CYC = 4, DEPTH = 8)
REQ-032 Program {0x11,d=1},{0x22,d=2},{0x33,d=0}; start, play_len=3, loop_en=0 -> gesture 0x11 for 4 cycles, 0x22 for 8, 0x33 for 4, done pulse 1 cycle, busy low, gesture stays 0x33.
REQ-033 Same program, loop_en=1 -> after 0x33 step, gesture returns to 0x11 with step=0, no done; abort -> next cycle gesture 0x00, busy 0, no done.
REQ-034 start with play_len=0 and play_len=9 -> busy stays 0, gesture unchanged.
REQ-035 wr_en to addr 1 with 0x55 during PLAY -> after sequence, replay shows original 0x22 at step 1.
REQ-036 start and abort same cycle in IDLE -> busy 0, gesture 0x00.
REQ-037 rst_n low mid-step 1 -> asynchronously gesture 0x00, busy 0; replay with play_len=1 shows prog[0] = 0x00.
